// File: rtl/synth_cmd_ctrl.sv
// Byte-framed command parser feeding the two oscillator configuration registers.
// Payloads are collected into a shadow register and committed atomically when the 0x00 terminator arrives.
module synth_cmd_ctrl #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int WAVE_MAX    = 5
) (
  input  logic        i_clk50mhz,
  input  logic        i_rst,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_byte,
  output logic [2:0]  o_osc1_wave,
  output logic [23:0] o_osc1_freq,
  output logic [15:0] o_osc1_phase,
  output logic [15:0] o_osc1_amp,
  output logic [2:0]  o_osc2_wave,
  output logic [23:0] o_osc2_freq,
  output logic [15:0] o_osc2_phase,
  output logic [15:0] o_osc2_amp,
  output logic [1:0]  o_update,
  output logic        o_err,
  output logic        o_busy
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, PAYLOAD, TERM} state_t;
  typedef enum logic [1:0] {F_WAVE, F_FREQ, F_PHASE, F_AMP} field_t;

  typedef struct packed {
    logic [2:0]  wave;
    logic [23:0] freq;
    logic [15:0] phase;
    logic [15:0] amp;
  } osc_cfg_t;

  localparam osc_cfg_t RESET_CFG = '{wave: 3'(WAVE_MAX), freq: '0, phase: '0, amp: '0};

  state_t        state_q, state_d;
  field_t        field_q, field_d;
  logic          osc_q, osc_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [23:0]   shadow_q, shadow_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          commit_q, commit_d;
  logic          err_q, err_d;
  logic [1:0]    update_q;
  logic          err_out_q;
  osc_cfg_t      live_q [2];

  logic       cmd_ok;
  logic [1:0] last_idx;

  assign cmd_ok = (i_rx_byte[7:5] == 3'b000) && (i_rx_byte[3:0] != 4'd0) && (i_rx_byte[3:0] <= 4'd4);

  always_comb begin
    case (field_q)
      F_WAVE:  last_idx = 2'd0;
      F_FREQ:  last_idx = 2'd2;
      default: last_idx = 2'd1;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    field_d  = field_q;
    osc_d    = osc_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    tmo_d    = '0;
    commit_d = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_rx_valid && (i_rx_byte != 8'h00)) begin
          if (cmd_ok) begin
            osc_d    = i_rx_byte[4];
            field_d  = field_t'(i_rx_byte[1:0] - 2'd1);
            shadow_d = '0;
            cnt_d    = '0;
            state_d  = PAYLOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      PAYLOAD: begin
        if (i_rx_valid) begin
          shadow_d[{cnt_q, 3'b000} +: 8] = i_rx_byte;
          if (cnt_q == last_idx) state_d = TERM;
          else                   cnt_d   = cnt_q + 2'd1;
        end
      end

      TERM: begin
        if (i_rx_valid) begin
          state_d = IDLE;
          if ((i_rx_byte != 8'h00) ||
              ((field_q == F_WAVE) && (shadow_q[7:0] > 8'(WAVE_MAX)))) err_d    = 1'b1;
          else                                                         commit_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Silence watchdog: a byte arriving on the expiry cycle takes precedence.
    if ((state_q != IDLE) && !i_rx_valid) begin
      if (tmo_q == CW'(TIMEOUT_CYC - 1)) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk50mhz or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      field_q   <= F_WAVE;
      osc_q     <= 1'b0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      tmo_q     <= '0;
      commit_q  <= 1'b0;
      err_q     <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      field_q   <= field_d;
      osc_q     <= osc_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      tmo_q     <= tmo_d;
      commit_q  <= commit_d;
      err_q     <= err_d;
      err_out_q <= err_q;
    end
  end

  // A new command may load osc/field/shadow on the same edge; the commit still sees the old values.
  always_ff @(posedge i_clk50mhz or posedge i_rst) begin
    if (i_rst) begin
      update_q <= '0;
      for (int i = 0; i < 2; i++) live_q[i] <= RESET_CFG;
    end else begin
      update_q <= '0;
      if (commit_q) begin
        update_q[osc_q] <= 1'b1;
        case (field_q)
          F_WAVE:  live_q[osc_q].wave  <= shadow_q[2:0];
          F_FREQ:  live_q[osc_q].freq  <= shadow_q;
          F_PHASE: live_q[osc_q].phase <= shadow_q[15:0];
          default: live_q[osc_q].amp   <= shadow_q[15:0];
        endcase
      end
    end
  end

  assign o_osc1_wave  = live_q[0].wave;
  assign o_osc1_freq  = live_q[0].freq;
  assign o_osc1_phase = live_q[0].phase;
  assign o_osc1_amp   = live_q[0].amp;
  assign o_osc2_wave  = live_q[1].wave;
  assign o_osc2_freq  = live_q[1].freq;
  assign o_osc2_phase = live_q[1].phase;
  assign o_osc2_amp   = live_q[1].amp;
  assign o_update     = update_q;
  assign o_err        = err_out_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_synth_cmd_ctrl.sv
// Randomized and directed frame stimulus for synth_cmd_ctrl, checked every cycle against
// a frame-level model (open frame kept as a byte queue, value assembled arithmetically).
module tb_synth_cmd_ctrl;

  localparam int TMO  = 40;
  localparam int WMAX = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [2:0]  osc1_wave, osc2_wave;
  logic [23:0] osc1_freq, osc2_freq;
  logic [15:0] osc1_phase, osc2_phase, osc1_amp, osc2_amp;
  logic [1:0]  update;
  logic        err, busy;

  synth_cmd_ctrl #(.TIMEOUT_CYC(TMO), .WAVE_MAX(WMAX)) dut (
    .i_clk50mhz  (clk),
    .i_rst       (rst),
    .i_rx_valid  (rx_valid),
    .i_rx_byte   (rx_byte),
    .o_osc1_wave (osc1_wave),
    .o_osc1_freq (osc1_freq),
    .o_osc1_phase(osc1_phase),
    .o_osc1_amp  (osc1_amp),
    .o_osc2_wave (osc2_wave),
    .o_osc2_freq (osc2_freq),
    .o_osc2_phase(osc2_phase),
    .o_osc2_amp  (osc2_amp),
    .o_update    (update),
    .o_err       (err),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int seen_err = 0;
  int seen_u1 = 0;
  int seen_u2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  frame[$];
  int          silence;
  logic [2:0]  m_wave [2];
  logic [23:0] m_freq [2];
  logic [15:0] m_phase[2];
  logic [15:0] m_amp  [2];
  logic [1:0]  m_upd;
  logic        m_err;
  logic        m_busy;
  logic [1:0]  pend_upd;
  logic        pend_err;
  int          pend_osc;
  int          pend_field;
  int unsigned pend_val;

  function automatic bit legal_cmd(input logic [7:0] b);
    return (b[7:4] < 2) && (b[3:0] >= 1) && (b[3:0] <= 4);
  endfunction

  function automatic int payload_len(input logic [3:0] f);
    case (f)
      4'd1:    return 1;
      4'd2:    return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    frame.delete();
    silence  = 0;
    m_upd    = '0;
    m_err    = 1'b0;
    m_busy   = 1'b0;
    pend_upd = '0;
    pend_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_wave[i]  = 3'(WMAX);
      m_freq[i]  = '0;
      m_phase[i] = '0;
      m_amp[i]   = '0;
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    logic [7:0]  head;
    int unsigned val;
    m_upd = pend_upd;
    m_err = pend_err;
    if (pend_upd != 2'b00) begin
      case (pend_field)
        1:       m_wave[pend_osc]  = pend_val[2:0];
        2:       m_freq[pend_osc]  = pend_val[23:0];
        3:       m_phase[pend_osc] = pend_val[15:0];
        default: m_amp[pend_osc]   = pend_val[15:0];
      endcase
    end
    pend_upd = '0;
    pend_err = 1'b0;

    if (frame.size() == 0) begin
      silence = 0;
      if (v && b != 8'h00) begin
        if (legal_cmd(b)) frame.push_back(b);
        else              pend_err = 1'b1;
      end
    end else if (v) begin
      silence = 0;
      head = frame[0];
      if (frame.size() < 1 + payload_len(head[3:0])) begin
        frame.push_back(b);
      end else begin
        if (b != 8'h00) begin
          pend_err = 1'b1;
        end else begin
          val = 0;
          for (int k = 0; k < payload_len(head[3:0]); k++)
            val = val + (32'(frame[1 + k]) << (8 * k));
          if (head[3:0] == 4'd1 && val > WMAX) begin
            pend_err = 1'b1;
          end else begin
            pend_osc   = int'(head[4]);
            pend_field = int'(head[3:0]);
            pend_val   = val;
            pend_upd   = head[4] ? 2'b10 : 2'b01;
          end
        end
        frame.delete();
      end
    end else begin
      silence++;
      if (silence == TMO) begin
        pend_err = 1'b1;
        frame.delete();
        silence = 0;
      end
    end
    m_busy = (frame.size() != 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step(rx_valid, rx_byte);
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("update",     32'(update),     32'(m_upd));
        check("err",        32'(err),        32'(m_err));
        check("busy",       32'(busy),       32'(m_busy));
        check("osc1_wave",  32'(osc1_wave),  32'(m_wave[0]));
        check("osc1_freq",  32'(osc1_freq),  32'(m_freq[0]));
        check("osc1_phase", 32'(osc1_phase), 32'(m_phase[0]));
        check("osc1_amp",   32'(osc1_amp),   32'(m_amp[0]));
        check("osc2_wave",  32'(osc2_wave),  32'(m_wave[1]));
        check("osc2_freq",  32'(osc2_freq),  32'(m_freq[1]));
        check("osc2_phase", 32'(osc2_phase), 32'(m_phase[1]));
        check("osc2_amp",   32'(osc2_amp),   32'(m_amp[1]));
        if (err)       seen_err++;
        if (update[0]) seen_u1++;
        if (update[1]) seen_u2++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int u0;
    int r;
    logic [7:0] b;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("rst_wave",   32'(osc1_wave),  32'd5);
    check("rst_freq",   32'(osc1_freq),  32'd0);
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_update", 32'(update),     32'd0);
    @(posedge clk);
    #1;

    // 1: wave commit of an identical value still pulses update
    u0 = seen_u1;
    send(8'h00); send(8'h01); send(8'h05); send(8'h00);
    idle(2);
    check("t1_wave", 32'(osc1_wave), 32'd5);
    check("t1_upd_pulses", 32'(seen_u1 - u0), 32'd1);
    check("t1_no_err", 32'(seen_err), 32'd0);

    // 2: freq then OSC2 amp, OSC1 untouched
    send(8'h02); send(8'hFF); send(8'hFF); send(8'h00); send(8'h00);
    idle(2);
    check("t2_freq", 32'(osc1_freq), 32'h00FFFF);
    send(8'h14); send(8'hFF); send(8'h7F); send(8'h00);
    idle(2);
    check("t2_amp2", 32'(osc2_amp), 32'h7FFF);
    check("t2_freq_kept", 32'(osc1_freq), 32'h00FFFF);
    check("t2_upd2_pulses", 32'(seen_u2), 32'd1);

    // 3: illegal wave, bad terminator, following 0x00 ignored
    e0 = seen_err;
    send(8'h01); send(8'h06); send(8'h00);
    idle(2);
    check("t3_wave_err", 32'(seen_err - e0), 32'd1);
    check("t3_wave_kept", 32'(osc1_wave), 32'd5);
    send(8'h03); send(8'h34); send(8'h12); send(8'hAA); send(8'h00);
    idle(2);
    check("t3_term_err", 32'(seen_err - e0), 32'd2);
    check("t3_phase_kept", 32'(osc1_phase), 32'd0);

    // 4: timeout mid-frame, then a clean frame
    send(8'h02); send(8'h11);
    idle(TMO + 3);
    check("t4_tmo_err", 32'(seen_err - e0), 32'd3);
    check("t4_busy", 32'(busy), 32'd0);
    send(8'h02); send(8'h01); send(8'h02); send(8'h03); send(8'h00);
    idle(2);
    check("t4_freq", 32'(osc1_freq), 32'h030201);

    // 5: byte on the expiry cycle wins; async reset mid-frame
    send(8'h02);
    idle(TMO - 1);
    send(8'h55);
    check("t5_busy_kept", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_freq", 32'(osc1_freq), 32'd0);
    check("t5_rst_wave", 32'(osc1_wave), 32'd5);
    check("t5_rst_amp2", 32'(osc2_amp), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_no_tmo_err", 32'(seen_err - e0), 32'd3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h04); send(8'hFF); send(8'hFF); send(8'h00);
    idle(2);
    check("t5_amp", 32'(osc1_amp), 32'hFFFF);

    // 6: back-to-back phase frame
    send(8'h03); send(8'h78); send(8'h56); send(8'h00);
    idle(2);
    check("t6_phase", 32'(osc1_phase), 32'h5678);

    // Random byte stream, occasionally stalled to around the timeout
    repeat (400) begin
      r = $urandom_range(0, 9);
      if (r < 3)      b = 8'h00;
      else if (r < 6) b = {3'b000, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 4))};
      else            b = 8'($urandom_range(0, 255));
      send(b);
      if ($urandom_range(0, 40) == 0) idle(TMO - 1 + $urandom_range(0, 1));
      else                            idle($urandom_range(0, 2));
    end
    idle(TMO + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
